// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one word-access data memory between two requesters.
// States: IDLE = wait for req | ISSUE = gnt + memory strobe | RESP = read data valid.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic                  last_grant;
  logic                  win;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  any_req;
  logic                  pick;
  logic                  aligned;

  // On a tie the port that did not win last time goes first.
  assign any_req = req0 | req1;
  assign pick    = (req0 && req1) ? ~last_grant : req1;
  assign aligned = (addr_r[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      win        <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else if (state == IDLE && any_req) begin
      last_grant <= pick;
      win        <= pick;
      we_r       <= pick ? we1 : we0;
      addr_r     <= pick ? addr1 : addr0;
      wdata_r    <= pick ? wdata1 : wdata0;
    end
  end

  always_comb begin
    state_nx = state;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    err0     = 1'b0;
    err1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        gnt0   = ~win;
        gnt1   = win;
        err0   = ~win & ~aligned;
        err1   = win & ~aligned;
        mem_we = aligned & we_r;
        mem_re = aligned & ~we_r;
        state_nx = (aligned && !we_r) ? RESP : IDLE;
      end
      RESP: begin
        rvalid0  = ~win;
        rvalid1  = win;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign rdata     = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer in front of the single-port, byte-addressed, word-access data memory (registered read, one-cycle read latency, synchronous write). It shares the memory between requester 0 (core load/store path) and requester 1 (loader/debug port). Selection is round-robin, with a req/gnt handshake and a read-response valid strobe. It sequences each access and rejects misaligned word addresses without touching memory.

## Interface
- ADDR_WIDTH, 32, byte-address width on both sides
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes per access)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  access request; held until gnt of same port
- we0, we1  in  1  1 = write, 0 = read; held with req
- addr0, addr1  in  ADDR_WIDTH  byte address; held with req
- wdata0, wdata1  in  32  write word; held with req
- gnt0, gnt1  out  1  one-cycle pulse: request accepted (and written, or rejected)
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata holds read result for that port
- err0, err1  out  1  one-cycle pulse coincident with gnt: misaligned, no access made
- rdata  out  32  read word, shared; meaningful only while an rvalid is high
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  32  memory write data
- mem_re, mem_we  out  1  memory read/write enables; never both high
- mem_rdata  in  32  memory registered read data

## Operation
- Moore FSM, states IDLE, ISSUE, RESP; reset state IDLE.
- IDLE: if no req, stay. Otherwise pick a winner and latch its port id, we, addr, wdata into registers, then go to ISSUE.
- Arbitration: a single requester wins. If both request, the port other than last_grant wins. last_grant updates on every acceptance and resets to 1, so port 0 wins the first tie.
- ISSUE: gnt[winner]=1. mem_addr/mem_wdata come from the latched registers.
  - Aligned (addr[1:0]==0), write: mem_we=1; next state IDLE.
  - Aligned, read: mem_re=1; next state RESP.
  - Misaligned: err[winner]=1, mem_re=mem_we=0; next state IDLE.
- RESP: rvalid[winner]=1; next state IDLE.
- rdata = mem_rdata, combinational pass-through.
- Requests are not re-sampled outside IDLE. A requester must deassert req on the edge ending its gnt cycle, or it is treated as a new request in the following IDLE.
- Writes never overlap reads. Each access is atomic to the winner.

## Timing
- Reset values (async, immediate): state IDLE, last_grant=1, latched regs 0, and gnt*, rvalid*, err*, mem_re, mem_we, mem_addr, mem_wdata all 0.
- Request first seen high in IDLE at cycle N:
  - gnt and mem strobe in cycle N+1.
  - Write commits at the edge ending N+1.
  - Read data and rvalid in N+2.
- Occupancy: write and misaligned take 2 cycles (IDLE+ISSUE); read takes 3 cycles.
- Back-to-back writes from one port: one write per 2 cycles.
- Both ports streaming: accepted order alternates 0,1,0,1.
- All strobes are single-cycle and are decoded from registered state, with no combinational input-to-output paths except rdata.
- Reset asserted during ISSUE drops mem_we before the next edge, so no write occurs. Reset during RESP suppresses rvalid. The requester must reissue after reset.
- Requests arriving while not in IDLE wait; there is no loss and no queue beyond the held req.

## Test plan
- Reset: assert rst mid-cycle with req0=1 → all outputs 0 immediately; after release, the first gnt0 appears 2 cycles later.
- Write then read: port 0 writes 0x11223344 at 0x10. Port 1 then reads 0x10 → gnt1 one cycle after it is sampled; rvalid1 next cycle with rdata=0x11223344. The bytes at 0x10..0x13 = 11,22,33,44.
- Tie: req0 and req1 both reads, rising in the same cycle after reset → gnt0 first, then gnt1. With both held continuously over 4 accesses → grant order 0,1,0,1.
- Misaligned: port 1 writes 0xDEADBEEF at 0x22 → gnt1 and err1 in the same cycle, mem_we never 1. A subsequent read of 0x20 returns the prior contents.
- Held req: port 0 keeps req0 high through 3 grants → 3 distinct transactions, each 3 cycles apart for reads. req1 raised mid-stream is granted next.
- Reset mid-op: port 0 write to 0x30 with rst pulsed during ISSUE (before the edge) → memory at 0x30 unchanged, FSM in IDLE.
